// File: rtl/mem_map_pkg.sv
// Address map, status-bit layout and read-source decode for the memory responder.
// Latency: n/a (constants, types and a pure decode function).
// Backpressure: n/a.
package mem_map_pkg;

    // Last RAM byte; everything above it belongs to the I/O page.
    localparam logic [7:0] RAM_TOP = 8'hEF;
    localparam logic [7:0] IO_BASE = 8'hF0;

    // I/O page registers.
    localparam logic [7:0] IO_SW   = 8'hF0;
    localparam logic [7:0] IO_LED  = 8'hF1;
    localparam logic [7:0] IO_TLO  = 8'hF2;
    localparam logic [7:0] IO_THI  = 8'hF3;
    localparam logic [7:0] IO_STAT = 8'hF4;

    // Position of the overflow flag inside the status byte.
    localparam int OVF_BIT = 0;

    // Which source drives the read mux for a given address.
    typedef enum logic [2:0] {
        SEL_RAM  = 3'd0,
        SEL_SW   = 3'd1,
        SEL_LED  = 3'd2,
        SEL_TLO  = 3'd3,
        SEL_THI  = 3'd4,
        SEL_STAT = 3'd5,
        SEL_NONE = 3'd6
    } sel_e;

    // Map a byte address to its read source; unused I/O addresses read as zero.
    function automatic sel_e decode_addr(input logic [7:0] addr);
        sel_e sel;
        if (addr <= RAM_TOP) begin
            sel = SEL_RAM;
        end else begin
            case (addr)
                IO_SW:   sel = SEL_SW;
                IO_LED:  sel = SEL_LED;
                IO_TLO:  sel = SEL_TLO;
                IO_THI:  sel = SEL_THI;
                IO_STAT: sel = SEL_STAT;
                default: sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/mem_responder_io_timer.sv
// Free-running 16-bit cycle timer with high-byte snapshot and sticky overflow flag.
// Latency: clear/latch/read-clear take effect at the edge they are sampled on; outputs are registers.
// Backpressure: none; controls are single-cycle strobes and are always accepted.
module io_timer
    import mem_map_pkg::*;
(
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       clr_i,      // processor write to the low byte: load zero
    input  logic       tlo_rd_i,   // processor read of the low byte: snapshot high byte
    input  logic       stat_rd_i,  // processor read of status: clear overflow
    output logic [7:0] tlo_o,
    output logic [7:0] thi_o,
    output logic [7:0] stat_o
);

    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  hi_snap_q, hi_snap_d;
    logic        ovf_q, ovf_d;
    logic        wrap;

    // Next-state: a clear overrides the increment, and a wrap beats a read-clear of ovf.
    always_comb begin
        wrap      = 1'b0;
        cnt_d     = cnt_q + 16'd1;
        hi_snap_d = hi_snap_q;
        ovf_d     = ovf_q;

        if (clr_i) begin
            cnt_d = 16'h0000;
        end else if (cnt_q == 16'hFFFF) begin
            wrap = 1'b1;
        end

        if (tlo_rd_i) begin
            hi_snap_d = cnt_q[15:8];
        end

        if (wrap) begin
            ovf_d = 1'b1;
        end else if (stat_rd_i) begin
            ovf_d = 1'b0;
        end
    end

    // Timer state registers with synchronous reset.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cnt_q     <= 16'h0000;
            hi_snap_q <= 8'h00;
            ovf_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            hi_snap_q <= hi_snap_d;
            ovf_q     <= ovf_d;
        end
    end

    // Present the pre-edge values to the read mux; status carries only the ovf bit.
    always_comb begin
        tlo_o           = cnt_q[7:0];
        thi_o           = hi_snap_q;
        stat_o          = 8'h00;
        stat_o[OVF_BIT] = ovf_q;
    end

endmodule

// File: rtl/mem_responder.sv
// Byte-wide memory responder: 240-byte RAM, switch/LED/timer I/O page, host loader port.
// Latency: reads return in q one edge after MemRead; writes land at the sampling edge.
// Backpressure: loader is stalled (ld_ready=0) on any processor request cycle or during reset.
module mem_responder
    import mem_map_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       MemRead,
    input  logic       wren,
    input  logic [7:0] address,
    input  logic [7:0] data,
    output logic [7:0] q,
    input  logic [7:0] sw,
    output logic [7:0] led,
    input  logic       ld_valid,
    input  logic [7:0] ld_addr,
    input  logic [7:0] ld_data,
    output logic       ld_ready
);

    localparam int RAM_DEPTH = int'(RAM_TOP) + 1;

    logic [7:0] mem_q [0:RAM_DEPTH-1];
    logic [7:0] q_q, q_d;
    logic [7:0] led_q, led_d;

    sel_e       rd_sel;
    logic       cpu_is_ram;
    logic       ld_is_ram;
    logic       ld_fire;
    logic       ram_we;
    logic [7:0] ram_waddr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;

    logic       tmr_clr;
    logic       tmr_lo_rd;
    logic       tmr_stat_rd;
    logic [7:0] tmr_lo;
    logic [7:0] tmr_hi;
    logic [7:0] tmr_stat;

    // The processor owns the bus whenever it requests; the loader only gets idle cycles.
    assign ld_ready = ~(MemRead | wren) & ~reset;

    // Decode request targets and build the single RAM write port.
    always_comb begin
        rd_sel      = decode_addr(address);
        cpu_is_ram  = (address <= RAM_TOP);
        ld_is_ram   = (ld_addr <= RAM_TOP);
        ld_fire     = ld_valid & ld_ready;

        tmr_clr     = ~reset & wren    & (address == IO_TLO);
        tmr_lo_rd   = ~reset & MemRead & (address == IO_TLO);
        tmr_stat_rd = ~reset & MemRead & (address == IO_STAT);

        ram_we    = 1'b0;
        ram_waddr = address;
        ram_wdata = data;
        if (!reset) begin
            if (wren && cpu_is_ram) begin
                ram_we = 1'b1;
            end else if (ld_fire && ld_is_ram) begin
                // Loader bytes aimed at the I/O page are acknowledged but dropped.
                ram_we    = 1'b1;
                ram_waddr = ld_addr;
                ram_wdata = ld_data;
            end
        end
    end

    // RAM write port; contents survive reset so preloaded programs are kept.
    always_ff @(posedge clock) begin
        if (ram_we) begin
            mem_q[ram_waddr] <= ram_wdata;
        end
    end

    // Only index the array with in-range addresses; the mux ignores this value otherwise.
    always_comb begin
        ram_rdata = 8'h00;
        if (cpu_is_ram) begin
            ram_rdata = mem_q[address];
        end
    end

    // Read mux uses pre-edge state, which gives read-before-write on a same-address hit.
    always_comb begin
        q_d   = q_q;
        led_d = led_q;
        if (MemRead) begin
            case (rd_sel)
                SEL_RAM:  q_d = ram_rdata;
                SEL_SW:   q_d = sw;
                SEL_LED:  q_d = led_q;
                SEL_TLO:  q_d = tmr_lo;
                SEL_THI:  q_d = tmr_hi;
                SEL_STAT: q_d = tmr_stat;
                default:  q_d = 8'h00;
            endcase
        end
        if (wren && (address == IO_LED)) begin
            led_d = data;
        end
    end

    // Read-data and LED registers with synchronous reset; requests are ignored in reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            q_q   <= 8'h00;
            led_q <= 8'h00;
        end else begin
            q_q   <= q_d;
            led_q <= led_d;
        end
    end

    assign q   = q_q;
    assign led = led_q;

    io_timer u_io_timer (
        .clock_i   (clock),
        .reset_i   (reset),
        .clr_i     (tmr_clr),
        .tlo_rd_i  (tmr_lo_rd),
        .stat_rd_i (tmr_stat_rd),
        .tlo_o     (tmr_lo),
        .thi_o     (tmr_hi),
        .stat_o    (tmr_stat)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: RAM, I/O page, timer, overflow, loader and reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Each scenario task compares against hand-computed values.
module tb_mem_responder;

    logic       clock;
    logic       reset;
    logic       MemRead;
    logic       wren;
    logic [7:0] address;
    logic [7:0] data;
    logic [7:0] q;
    logic [7:0] sw;
    logic [7:0] led;
    logic       ld_valid;
    logic [7:0] ld_addr;
    logic [7:0] ld_data;
    logic       ld_ready;

    int checks = 0;
    int errors = 0;

    mem_responder dut (
        .clock    (clock),
        .reset    (reset),
        .MemRead  (MemRead),
        .wren     (wren),
        .address  (address),
        .data     (data),
        .q        (q),
        .sw       (sw),
        .led      (led),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .ld_ready (ld_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One processor request through one rising edge, then back to idle.
    task automatic op(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
        MemRead = rd;
        wren    = wr;
        address = a;
        data    = d;
        @(posedge clock);
        #1;
        MemRead = 1'b0;
        wren    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if (ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ld_ready got %b want 0", ld_ready);
        end
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        checks++;
        if (q !== 8'h00) begin
            errors++;
            $display("FAIL reset_q got %h want 00", q);
        end
        checks++;
        if (led !== 8'h00) begin
            errors++;
            $display("FAIL reset_led got %h want 00", led);
        end
        op(1'b1, 1'b0, 8'hF4, 8'h00);
        checks++;
        if (q !== 8'h00) begin
            errors++;
            $display("FAIL reset_stat got %h want 00", q);
        end
        op(1'b1, 1'b0, 8'hF3, 8'h00);
        checks++;
        if (q !== 8'h00) begin
            errors++;
            $display("FAIL reset_hisnap got %h want 00", q);
        end
    endtask

    task automatic test_basic_rw();
        op(1'b0, 1'b1, 8'h10, 8'h5A);
        checks++;
        if (q !== 8'h00) begin
            errors++;
            $display("FAIL write_no_q got %h want 00", q);
        end
        op(1'b1, 1'b0, 8'h10, 8'h00);
        checks++;
        if (q !== 8'h5A) begin
            errors++;
            $display("FAIL read_10 got %h want 5a", q);
        end
        // q holds while idle
        @(posedge clock);
        #1;
        checks++;
        if (q !== 8'h5A) begin
            errors++;
            $display("FAIL q_hold got %h want 5a", q);
        end
    endtask

    task automatic test_read_before_write();
        op(1'b0, 1'b1, 8'h20, 8'h11);
        op(1'b1, 1'b1, 8'h20, 8'h99);
        checks++;
        if (q !== 8'h11) begin
            errors++;
            $display("FAIL rbw_old got %h want 11", q);
        end
        op(1'b1, 1'b0, 8'h20, 8'h00);
        checks++;
        if (q !== 8'h99) begin
            errors++;
            $display("FAIL rbw_new got %h want 99", q);
        end
    endtask

    task automatic test_io_page();
        op(1'b0, 1'b1, 8'hF1, 8'h3C);
        checks++;
        if (led !== 8'h3C) begin
            errors++;
            $display("FAIL led_write got %h want 3c", led);
        end
        op(1'b1, 1'b0, 8'hF1, 8'h00);
        checks++;
        if (q !== 8'h3C) begin
            errors++;
            $display("FAIL led_read got %h want 3c", q);
        end
        op(1'b0, 1'b1, 8'hF0, 8'h77);
        op(1'b1, 1'b0, 8'hF0, 8'h00);
        checks++;
        if (q !== 8'hC3) begin
            errors++;
            $display("FAIL sw_read got %h want c3", q);
        end
        op(1'b0, 1'b1, 8'hF5, 8'h55);
        op(1'b1, 1'b0, 8'hF5, 8'h00);
        checks++;
        if (q !== 8'h00) begin
            errors++;
            $display("FAIL unused_read got %h want 00", q);
        end
    endtask

    task automatic test_loader();
        op(1'b0, 1'b1, 8'h30, 8'h00);
        ld_valid = 1'b1;
        ld_addr  = 8'h30;
        ld_data  = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            MemRead = 1'b1;
            address = 8'h30;
            #1;
            checks++;
            if (ld_ready !== 1'b0) begin
                errors++;
                $display("FAIL ld_stall_ready cyc %0d got %b want 0", i, ld_ready);
            end
            @(posedge clock);
            #1;
            checks++;
            if (q !== 8'h00) begin
                errors++;
                $display("FAIL ld_stall_mem cyc %0d got %h want 00", i, q);
            end
        end
        MemRead = 1'b0;
        #1;
        checks++;
        if (ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL ld_idle_ready got %b want 1", ld_ready);
        end
        @(posedge clock);
        #1;
        ld_valid = 1'b0;
        op(1'b1, 1'b0, 8'h30, 8'h00);
        checks++;
        if (q !== 8'hA5) begin
            errors++;
            $display("FAIL ld_data got %h want a5", q);
        end
        // Loader byte aimed at the LED register is dropped.
        ld_valid = 1'b1;
        ld_addr  = 8'hF1;
        ld_data  = 8'hEE;
        @(posedge clock);
        #1;
        ld_valid = 1'b0;
        checks++;
        if (led !== 8'h3C) begin
            errors++;
            $display("FAIL ld_io_drop got %h want 3c", led);
        end
    endtask

    task automatic test_timer();
        // Clear edge leaves 0; 300 idle edges bring it to 300 = 0x012C before the read edge.
        op(1'b0, 1'b1, 8'hF2, 8'hAB);
        repeat (300) @(posedge clock);
        #1;
        op(1'b1, 1'b0, 8'hF2, 8'h00);
        checks++;
        if (q !== 8'h2C) begin
            errors++;
            $display("FAIL timer_lo got %h want 2c", q);
        end
        op(1'b1, 1'b0, 8'hF3, 8'h00);
        checks++;
        if (q !== 8'h01) begin
            errors++;
            $display("FAIL timer_hi got %h want 01", q);
        end
    endtask

    task automatic test_overflow();
        // After the clear edge, 65535 idle edges leave the counter at 0xFFFF.
        op(1'b0, 1'b1, 8'hF2, 8'h00);
        repeat (65535) @(posedge clock);
        #1;
        // Status read on the wrap edge: returns old ovf, set wins over the clear.
        op(1'b1, 1'b0, 8'hF4, 8'h00);
        checks++;
        if (q !== 8'h00) begin
            errors++;
            $display("FAIL ovf_wrap_read got %h want 00", q);
        end
        op(1'b1, 1'b0, 8'hF4, 8'h00);
        checks++;
        if (q !== 8'h01) begin
            errors++;
            $display("FAIL ovf_set got %h want 01", q);
        end
        op(1'b1, 1'b0, 8'hF4, 8'h00);
        checks++;
        if (q !== 8'h00) begin
            errors++;
            $display("FAIL ovf_cleared got %h want 00", q);
        end
    endtask

    task automatic test_mid_reset();
        reset   = 1'b1;
        MemRead = 1'b1;
        wren    = 1'b1;
        address = 8'h10;
        data    = 8'hFF;
        @(posedge clock);
        #1;
        reset   = 1'b0;
        MemRead = 1'b0;
        wren    = 1'b0;
        checks++;
        if (led !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_led got %h want 00", led);
        end
        checks++;
        if (q !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_q got %h want 00", q);
        end
        op(1'b1, 1'b0, 8'h10, 8'h00);
        checks++;
        if (q !== 8'h5A) begin
            errors++;
            $display("FAIL ram_kept got %h want 5a", q);
        end
    endtask

    initial begin
        reset    = 1'b1;
        MemRead  = 1'b0;
        wren     = 1'b0;
        address  = 8'h00;
        data     = 8'h00;
        sw       = 8'hC3;
        ld_valid = 1'b0;
        ld_addr  = 8'h00;
        ld_data  = 8'h00;
        test_reset();
        test_basic_rw();
        test_read_before_write();
        test_io_page();
        test_loader();
        test_timer();
        test_overflow();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Responder side of the processor's byte-wide memory interface.
- Services the processor's MemRead/wren requests against a 240-byte RAM and a small memory-mapped I/O page: switches, LED register, and a 16-bit cycle timer with an overflow flag.
- Also accepts a host loader write stream through a valid/ready handshake, used to preload programs.
- Sits in place of the plain data memory in the top level, on the address/data/q bus driven by AddrSel_mux and MemIn_mux.

Parameters:
- RAM_TOP, 8'hEF, last RAM address; addresses above it decode to the I/O page.
- IO_BASE, 8'hF0, first I/O address.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- MemRead  input  1  processor read request, sampled at posedge.
- wren  input  1  processor write request, sampled at posedge.
- address  input  8  processor byte address.
- data  input  8  processor write data.
- q  output  8  registered read data.
- sw  input  8  switch inputs, read at 0xF0.
- led  output  8  LED register, written and read at 0xF1.
- ld_valid  input  1  loader has a byte to write.
- ld_addr  input  8  loader address; RAM range only.
- ld_data  input  8  loader byte.
- ld_ready  output  1  loader byte accepted this cycle (combinational).

Behaviour:
- Reset (synchronous, at posedge with reset=1):
  - q=0, led=0, counter=0, hi_snap=0, ovf=0.
  - RAM contents are not cleared.
  - Processor and loader requests in that cycle are ignored.
- Address map:
  - 0x00-0xEF: RAM.
  - 0xF0: sw (read only).
  - 0xF1: led (read/write).
  - 0xF2: counter[7:0]. A read also latches counter[15:8] into hi_snap. A write of any value clears the counter.
  - 0xF3: hi_snap (read only).
  - 0xF4: status. Bit0 = ovf, bits 7:1 = 0. A read clears ovf.
  - 0xF5-0xFF: read 0, writes ignored.
  - Writes to read-only locations are ignored.
- Read latency is 1 cycle:
  - At a posedge with MemRead=1, q takes the value at address; it is valid from that edge onward.
  - q holds its value when MemRead=0.
- Writes: at a posedge with wren=1, data is stored to the addressed location.
- MemRead=1 and wren=1 together at the same address: read-before-write. q gets the old value and the location gets data.
- Timer counter:
  - 16-bit free-running; increments by 1 every non-reset cycle.
  - Wraps from 0xFFFF to 0x0000 and sets ovf on the wrap.
  - A processor write to 0xF2 loads 0 and suppresses that cycle's increment.
- ovf precedence: if a set (wrap) and a clear (read of 0xF4) happen in the same cycle, the set wins. The read returns the pre-edge ovf value.
- Reading 0xF2 returns the pre-edge counter value. hi_snap takes the pre-edge counter[15:8].
- Loader handshake:
  - ld_ready = ~(MemRead | wren) & ~reset.
  - A byte is written when ld_valid & ld_ready at a posedge, and only if ld_addr <= RAM_TOP. Bytes aimed at the I/O page are acknowledged and dropped.
  - The processor always has priority. A loader byte stalls (ld_valid held, ld_ready=0) until a processor-idle cycle.
  - ld_addr, ld_data and ld_valid must stay stable while ld_ready=0.
- Processor data must never change state on a non-request cycle.

Decomposition:
- Package mem_map_pkg: address constants (RAM_TOP, IO_SW=F0, IO_LED=F1, IO_TLO=F2, IO_THI=F3, IO_STAT=F4) and the status bit index OVF_BIT=0.
- Sub-module io_timer: 16-bit counter, hi_snap, ovf, and the clear/latch/read-clear controls. Its outputs are tlo, thi and stat.
- The top module holds the RAM array, address decode, read mux, q register, led register and loader arbitration.

Test Plan:
- Reset, then write 0x5A to 0x10, then read 0x10 -> q=0x5A one edge after the read; q=0 before the first read.
- MemRead and wren together at 0x20 (old value 0x11, data 0x99) -> q=0x11; a following read of 0x20 gives q=0x99.
- Write 0x00 to 0xF2, wait 300 cycles, read 0xF2 then 0xF3 -> low byte 0x2C and hi_snap 0x01 (counter value 300 = 0x012C at the read edge). Compare against the bench's counter model.
- Force the counter to 0xFFFF via 65535 cycles after a clear -> ovf=1 on wrap. Read 0xF4 -> q=0x01; a second read -> q=0x00. A read on the exact wrap cycle -> ovf stays 1.
- ld_valid with 0xA5 to 0x30 during 3 consecutive MemRead cycles -> ld_ready=0 for those cycles, write accepted on the first idle cycle; a later read of 0x30 gives 0xA5. A loader write to 0xF1 -> led unchanged.
- Write 0x3C to 0xF1 -> led=0x3C; assert reset mid-sequence -> led=0, q=0, RAM[0x10] still 0x5A.
